// File: rtl/h80cpu_uart_tx_pkg.sv
// Shared h80cpu I/O bus types plus the UART TX register map.
//   bus_addr_t / bus_data_t : 16-bit I/O address and data words
//   bus_cmd_t               : bus command encoding
//   uart_reg_*              : register offsets decoded from addr[3:0]
//   uart_stat_*             : bit positions inside the STATUS word
//   tx_state_t              : serialiser states
package h80cpu_uart_tx_pkg;

    typedef logic [15:0] bus_addr_t;
    typedef logic [15:0] bus_data_t;

    typedef enum logic [2:0] {
        bus_idle = 3'd0,
        read_b   = 3'd1,
        read_w   = 3'd2,
        write_b  = 3'd3,
        write_w  = 3'd4
    } bus_cmd_t;

    localparam logic [3:0] uart_reg_txdata = 4'h0;
    localparam logic [3:0] uart_reg_status = 4'h2;

    localparam int uart_stat_active = 1;
    localparam int uart_stat_full   = 2;
    localparam int uart_stat_empty  = 3;

    typedef enum logic [1:0] {
        tx_idle  = 2'd0,
        tx_start = 2'd1,
        tx_data  = 2'd2,
        tx_stop  = 2'd3
    } tx_state_t;

    // Clocks per bit, rounded to nearest.
    function automatic int baud_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/h80cpu_uart_tx_fifo.sv
// Synchronous FIFO used as the UART TX byte queue.
//   clk, reset_ : clock, synchronous active-low reset (empties the queue)
//   push, push_data : enqueue; accepted when not full or when popping
//   pop         : dequeue; ignored when empty
//   full, empty : occupancy flags from the extra pointer MSB
//   head        : oldest entry, held in flops (valid while !empty)
module h80cpu_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ptr_one = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Push into a full queue only succeeds when the head leaves on the same edge.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + ptr_one;
            if (pop_ok)  rd_ptr <= rd_ptr + ptr_one;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/h80cpu_uart_tx.sv
// Buffered 8N1 UART transmitter, slave on the h80cpu I/O bus.
//   clk, reset_ : clock, synchronous active-low reset
//   addr, cmd, run, wr_data : bus request (pending while run != done)
//   rd_data, done           : read data and completion toggle
//   uart_txp                : serial line, idle high
// Registers (addr[3:0]): 0x0 TXDATA write-only, 0x2 STATUS read-only
//   STATUS = {12'h0, fifo_empty, fifo_full, tx_active, 1'b0}.
// Constraints: DIV = round(CLK_FREQ/BAUD) >= 2, FIFO_DEPTH power of 2 >= 2.
module h80cpu_uart_tx
    import h80cpu_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ   = 27000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic [15:0] addr,
    input  logic [2:0]  cmd,
    input  logic        run,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        done,
    output logic        uart_txp
);

    localparam int DIV = baud_div(CLK_FREQ, BAUD);
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] cnt_reload = CW'(DIV - 1);
    localparam logic [CW-1:0] cnt_one    = 1;

    tx_state_t   state;
    logic [CW-1:0] baud_cnt;
    logic [7:0]  shift;
    logic [2:0]  bitcnt;

    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_head;
    logic        fifo_pop;
    logic        fifo_push;

    logic        pending;
    bus_cmd_t    bus_cmd;
    logic        is_write;
    logic        is_read;
    logic [3:0]  reg_sel;
    logic        txdata_wr;
    logic        tx_active;
    logic        bit_end;
    bus_data_t   status_word;
    logic        unused_bits;

    assign unused_bits = ^{addr[15:4], wr_data[15:8]};

    assign pending   = (run != done);
    assign bus_cmd   = bus_cmd_t'(cmd);
    assign is_write  = (bus_cmd == write_b) || (bus_cmd == write_w);
    assign is_read   = (bus_cmd == read_b)  || (bus_cmd == read_w);
    assign reg_sel   = addr[3:0];
    assign txdata_wr = pending && is_write && (reg_sel == uart_reg_txdata);
    assign tx_active = (state != tx_idle);
    assign bit_end   = (baud_cnt == '0);

    // A push against a full queue waits for the edge on which the serialiser pops.
    assign fifo_push = txdata_wr && (!fifo_full || fifo_pop);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        fifo_pop = 1'b0;
        case (state)
            tx_idle: fifo_pop = !fifo_empty;
            tx_stop: fifo_pop = bit_end && !fifo_empty;
            default: fifo_pop = 1'b0;
        endcase
    end

    always_comb begin
        status_word                   = '0;
        status_word[uart_stat_active] = tx_active;
        status_word[uart_stat_full]   = fifo_full;
        status_word[uart_stat_empty]  = fifo_empty;
    end

    h80cpu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset_    (reset_),
        .push      (fifo_push),
        .push_data (wr_data[7:0]),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // Bus side: every pending request completes except a TXDATA write that
    // cannot enter the queue yet.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            done    <= 1'b0;
            rd_data <= '0;
        end else if (pending) begin
            if (txdata_wr) begin
                if (fifo_push) done <= ~done;
            end else begin
                done <= ~done;
                if (is_read) rd_data <= (reg_sel == uart_reg_status) ? status_word : '0;
            end
        end
    end

    // Serialiser: uart_txp is registered, so each level appears the clock
    // after the edge that decides it and every bit lasts exactly DIV clocks.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            state    <= tx_idle;
            baud_cnt <= '0;
            shift    <= '0;
            bitcnt   <= '0;
            uart_txp <= 1'b1;
        end else begin
            case (state)
                tx_idle: begin
                    if (fifo_pop) begin
                        shift    <= fifo_head;
                        bitcnt   <= '0;
                        baud_cnt <= cnt_reload;
                        uart_txp <= 1'b0;
                        state    <= tx_start;
                    end
                end
                tx_start: begin
                    if (bit_end) begin
                        baud_cnt <= cnt_reload;
                        uart_txp <= shift[0];
                        state    <= tx_data;
                    end else begin
                        baud_cnt <= baud_cnt - cnt_one;
                    end
                end
                tx_data: begin
                    if (bit_end) begin
                        baud_cnt <= cnt_reload;
                        if (bitcnt == 3'd7) begin
                            uart_txp <= 1'b1;
                            state    <= tx_stop;
                        end else begin
                            shift    <= {1'b0, shift[7:1]};
                            uart_txp <= shift[1];
                            bitcnt   <= bitcnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - cnt_one;
                    end
                end
                tx_stop: begin
                    if (bit_end) begin
                        if (fifo_pop) begin
                            // Back-to-back frame: no idle clock between stop and start.
                            shift    <= fifo_head;
                            bitcnt   <= '0;
                            baud_cnt <= cnt_reload;
                            uart_txp <= 1'b0;
                            state    <= tx_start;
                        end else begin
                            baud_cnt <= '0;
                            state    <= tx_idle;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - cnt_one;
                    end
                end
                default: state <= tx_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_h80cpu_uart_tx.sv
// Self-checking bench for h80cpu_uart_tx. A frame-level reference model
// (byte queue + position inside the current 10*DIV-clock frame) predicts
// uart_txp, done and rd_data every clock.
module tb_h80cpu_uart_tx;
    import h80cpu_uart_tx_pkg::*;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 250000;
    localparam int DIV      = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int DEPTH    = 8;
    localparam int FRAME    = 10 * DIV;
    localparam int BUDGET   = 20 * FRAME;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic [15:0] addr = '0;
    logic [2:0]  cmd = '0;
    logic        run = 1'b0;
    logic [15:0] wr_data = '0;
    logic [15:0] rd_data;
    logic        done;
    logic        uart_txp;

    h80cpu_uart_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset_   (reset_),
        .addr     (addr),
        .cmd      (cmd),
        .run      (run),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .done     (done),
        .uart_txp (uart_txp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    logic [7:0]  m_q[$];
    bit          m_busy = 0;
    int          m_k = 0;
    logic [7:0]  m_cur = '0;
    logic        m_done = 1'b0;
    logic [15:0] m_rd = '0;

    function automatic logic m_line();
        if (!m_busy)       return 1'b1;
        if (m_k < DIV)     return 1'b0;
        if (m_k < 9 * DIV) return m_cur[m_k / DIV - 1];
        return 1'b1;
    endfunction

    task automatic model_step(input logic s_rst, input logic s_run, input logic [2:0] s_cmd,
                              input logic [15:0] s_addr, input logic [15:0] s_wd);
        int          sz;
        bit          popped;
        bit          is_wr;
        bit          is_rd;
        logic [15:0] status;
        if (!s_rst) begin
            m_q.delete();
            m_busy = 0;
            m_k    = 0;
            m_done = 1'b0;
            m_rd   = '0;
            return;
        end
        sz     = m_q.size();
        status = {12'h0, sz == 0, sz == DEPTH, m_busy, 1'b0};
        popped = 0;
        if (!m_busy) begin
            if (sz > 0) begin
                m_cur  = m_q.pop_front();
                m_busy = 1;
                m_k    = 0;
                popped = 1;
            end
        end else if (m_k == FRAME - 1) begin
            if (sz > 0) begin
                m_cur  = m_q.pop_front();
                m_k    = 0;
                popped = 1;
            end else begin
                m_busy = 0;
            end
        end else begin
            m_k++;
        end
        if (s_run != m_done) begin
            is_wr = (s_cmd == 3'(write_b)) || (s_cmd == 3'(write_w));
            is_rd = (s_cmd == 3'(read_b))  || (s_cmd == 3'(read_w));
            if (is_wr && s_addr[3:0] == 4'h0) begin
                if (sz < DEPTH || popped) begin
                    m_q.push_back(s_wd[7:0]);
                    m_done = ~m_done;
                end
            end else begin
                if (is_rd) m_rd = (s_addr[3:0] == 4'h2) ? status : 16'h0;
                m_done = ~m_done;
            end
        end
    endtask

    // One clock: DUT and model both consume the inputs present before the edge.
    task automatic tick();
        logic        s_rst  = reset_;
        logic        s_run  = run;
        logic [2:0]  s_cmd  = cmd;
        logic [15:0] s_addr = addr;
        logic [15:0] s_wd   = wr_data;
        @(posedge clk);
        model_step(s_rst, s_run, s_cmd, s_addr, s_wd);
        #1;
        check("uart_txp", {15'h0, uart_txp}, {15'h0, m_line()});
        check("done",     {15'h0, done},     {15'h0, m_done});
        check("rd_data",  rd_data,           m_rd);
    endtask

    task automatic bus_req(input logic [2:0] c, input logic [15:0] a, input logic [15:0] d,
                           output int lat);
        cmd     = c;
        addr    = a;
        wr_data = d;
        run     = ~run;
        lat     = 0;
        do begin
            tick();
            lat++;
        end while (done !== run && lat < BUDGET);
        if (done !== run) check("req_timeout", {15'h0, done}, {15'h0, run});
        cmd = 3'(bus_idle);
    endtask

    task automatic drain();
        int guard = 0;
        while ((m_busy || m_q.size() != 0 || uart_txp !== 1'b1) && guard < BUDGET) begin
            tick();
            guard++;
        end
        tick();
    endtask

    initial begin
        int          lat;
        logic [9:0]  frame_bits;
        logic [2:0]  c;
        logic [3:0]  off;
        int          gap;

        // Reset for two clocks with run low.
        reset_ = 1'b0;
        run    = 1'b0;
        tick();
        tick();
        check("reset_done", {15'h0, done}, 16'h0);
        check("reset_txp",  {15'h0, uart_txp}, 16'h1);
        reset_ = 1'b1;
        tick();
        bus_req(3'(read_w), 16'h0002, 16'h0, lat);
        check("status_after_reset", rd_data, 16'h0008);
        check("status_lat", 16'(lat), 16'd1);

        // Single 0x55 frame, sampled bit by bit.
        bus_req(3'(write_b), 16'h0000, 16'h0055, lat);
        check("write_lat", 16'(lat), 16'd1);
        frame_bits = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < FRAME; i++) begin
            tick();
            check("frame55", {15'h0, uart_txp}, {15'h0, frame_bits[i / DIV]});
        end
        tick();
        check("frame55_idle", {15'h0, uart_txp}, 16'h1);
        drain();

        // "H","i" back-to-back: 80 clocks of line activity with no gap.
        bus_req(3'(write_b), 16'h0000, 16'h0048, lat);
        bus_req(3'(write_w), 16'h0000, 16'h0069, lat);   // sample 0 of frame "H"
        bus_req(3'(read_b), 16'h0002, 16'h0, lat);       // sample 1
        check("status_busy", rd_data, 16'h0002);
        repeat (2 * FRAME - 2) tick();
        tick();
        check("hi_end_idle", {15'h0, uart_txp}, 16'h1);
        bus_req(3'(read_w), 16'h0002, 16'h0, lat);
        check("status_idle", rd_data, 16'h0008);

        // Fill the queue behind a running frame, then wait on a full queue.
        bus_req(3'(write_b), 16'h0000, 16'h00A0, lat);
        tick();
        for (int i = 1; i <= DEPTH; i++) begin
            bus_req(3'(write_b), 16'h0000, 16'(8'hA0 + i), lat);
            check("fill_lat", 16'(lat), 16'd1);
        end
        bus_req(3'(read_w), 16'h0002, 16'h0, lat);
        check("status_full", rd_data, 16'h0006);
        bus_req(3'(read_w), 16'h0004, 16'h0, lat);
        check("unmapped_rd", rd_data, 16'h0000);
        check("unmapped_lat", 16'(lat), 16'd1);
        bus_req(3'(write_b), 16'h0000, 16'h00A9, lat);
        check("full_wait_lat", 16'(lat), 16'(FRAME - 10));
        drain();

        // Randomised traffic.
        for (int n = 0; n < 120; n++) begin
            int r = $urandom_range(0, 9);
            if (r < 5)      c = (r[0]) ? 3'(write_b) : 3'(write_w);
            else if (r < 8) c = (r[0]) ? 3'(read_b) : 3'(read_w);
            else            c = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0)  off = 4'($urandom_range(0, 15));
            else if (r < 5)                 off = 4'h0;
            else                            off = 4'h2;
            bus_req(c, (16'($urandom) & 16'hFFF0) | {12'h0, off}, 16'($urandom), lat);
            gap = $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) gap = 3 * FRAME;
            repeat (gap) tick();
        end
        drain();
        bus_req(3'(read_w), 16'h0002, 16'h0, lat);
        check("status_after_random", rd_data, 16'h0008);

        // Reset in the middle of a data bit.
        bus_req(3'(write_b), 16'h0000, 16'h00A5, lat);
        begin
            int guard = 0;
            while (!(m_busy && m_k >= DIV + DIV / 2) && guard < BUDGET) begin
                tick();
                guard++;
            end
        end
        reset_ = 1'b0;
        run    = 1'b0;
        tick();
        check("midreset_txp",  {15'h0, uart_txp}, 16'h1);
        check("midreset_done", {15'h0, done}, 16'h0);
        reset_ = 1'b1;
        bus_req(3'(read_w), 16'h0002, 16'h0, lat);
        check("midreset_status", rd_data, 16'h0008);
        bus_req(3'(write_b), 16'h0000, 16'h003C, lat);
        frame_bits = {1'b1, 8'h3C, 1'b0};
        for (int i = 0; i < FRAME; i++) begin
            tick();
            check("frame3c", {15'h0, uart_txp}, {15'h0, frame_bits[i / DIV]});
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/h80cpu_uart_tx.md
Name: h80cpu_uart_tx

Overview:
Buffered UART transmitter that is a slave on the h80cpu I/O bus. It serves OUTB/OUTW writes to the TX data register and reads of a status register. Bytes are queued in a small synchronous FIFO and serialised as 8N1 on uart_txp. It is driven directly by the CPU I/O bus (bus_run[BUS_IO]/bus_done[BUS_IO]) and replaces the unbuffered TX path inside the I/O block.

Parameters:
CLK_FREQ, 27000000, clk frequency in Hz
BAUD, 115200, line rate; DIV = (CLK_FREQ + BAUD/2) / BAUD clocks per bit, and DIV must be ≥ 2
FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2 and ≥ 2

Ports:
clk  in  1  clock; all state updates on posedge
reset_  in  1  synchronous, active-low reset
addr  in  16  bus_addr_t I/O address
cmd  in  3  bus_cmd_t bus command
run  in  1  request toggle from the CPU
wr_data  in  16  bus_data_t write data
rd_data  out  16  bus_data_t read data
done  out  1  completion toggle
uart_txp  out  1  serial TX line, idle high

Behaviour:
- Reset (reset_==0 at a posedge): done=0, rd_data=0, uart_txp=1, FIFO emptied, serialiser state IDLE, baud counter 0. A request in flight is dropped; the master resets its run to 0 in the same reset.
- Handshake: a request is pending while run != done. Each pending request toggles done exactly once. Inputs are sampled on the posedge where the request is pending. Nothing happens while run == done.
- Address decode uses addr[3:0]. 0x0 is TXDATA (write only). 0x2 is STATUS (read only). All other offsets are unmapped.
- write_w or write_b to 0x0 pushes wr_data[7:0].
  - FIFO not full: push and toggle done on the same edge (latency 1 clk).
  - FIFO full: the request stays pending and done is not toggled. The push is accepted on the edge where the serialiser pops, so count stays FIFO_DEPTH.
- read_w or read_b at 0x2 loads rd_data = {12'h0, fifo_empty, fifo_full, tx_active, 1'b0}, bits [3:0] as listed. done toggles on the same edge (latency 1).
- Any other access (unmapped offset, write to STATUS, read of TXDATA, odd byte address) completes in 1 clk with no side effect. Reads of these load rd_data=0.
- tx_active = 1 whenever the serialiser state != IDLE.
- Serialiser FSM: IDLE → START → DATA → STOP.
  - IDLE: uart_txp=1. If the FIFO is not empty, pop the head into shift[7:0], set bitcnt=0, baud counter=DIV-1, go to START.
  - START: uart_txp=0 for DIV clks, then go to DATA.
  - DATA: uart_txp=shift[0], LSB first. Each bit lasts DIV clks. Shift right after each bit. After bit 7, go to STOP.
  - STOP: uart_txp=1 for DIV clks. At the end of STOP, if the FIFO is not empty, pop and go straight to START with no idle cycle; otherwise go to IDLE.
- Frame length is exactly 10*DIV clks. uart_txp is registered, and the first start-bit clk is the one after the pop edge.
- The baud counter counts down from DIV-1 and is reloaded on every bit boundary. It does not run in IDLE.
- Simultaneous push into an empty FIFO and IDLE pop: the byte is visible to the serialiser on the next edge. There is no combinational bypass.

Decomposition:
- Shared package h80cpu.svh: bus_addr_t, bus_data_t, bus_cmd_t (existing). Add new constants uart_reg_txdata=4'h0, uart_reg_status=4'h2, and status bit indices uart_stat_active=1, uart_stat_full=2, uart_stat_empty=3.
- Sub-module h80cpu_fifo: synchronous FIFO with DEPTH/WIDTH parameters.
  - Interfaces: push/pop, full/empty, registered head.
  - Pointers are log2(DEPTH)+1 bits; full/empty come from the MSB compare.
  - Same-cycle push and pop when full is allowed.

Test Plan:
- Reset with reset_=0 for 2 clks, run=0 → done=0, uart_txp=1, then STATUS read gives rd_data=16'h0008 after 1 clk.
- CLK_FREQ=1000000, BAUD=250000 (DIV=4); write_b 0x0 data 8'h55 → done toggles in 1 clk. uart_txp shows 0 for 4 clks, then 1,0,1,0,1,0,1,0 for 4 clks each, then 1 for 4 clks; 40 clks total.
- Write "H","i" back-to-back → two frames with no idle gap: 80 clks from the first start edge to the end of the stop bit. STATUS reads 0x0002 during the frames and 0x0008 after.
- Fill the FIFO with 8 writes while the first byte is serialising, then issue a 10th write → done holds until the next pop, then toggles on the pop edge. All 10 bytes appear in order.
- STATUS read when full → 0x0006. Read of 0x4 → rd_data=0, done toggles, no FIFO change.
- Assert reset_ mid-DATA bit → uart_txp=1 on the reset edge, FIFO empty, and the next frame starts cleanly after a new write.
